// File: rtl/pong_ball_engine.sv
// Pong game engine: moves the ball once per video frame (falling edge of iVS),
// bounces it off the walls and paddle faces, scores misses and sequences serve/game-over.
module pong_ball_engine #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BALL_SIZE   = 20,
   parameter int PADDLE_W    = 20,
   parameter int PADDLE_H    = 100,
   parameter int PL_X        = 100,
   parameter int PR_X        = 500,
   parameter int VEL_X       = 3,
   parameter int VEL_Y       = 2,
   parameter int SERVE_DELAY = 60,
   parameter int WIN_SCORE   = 9
) (
   input  logic        iVGA_CLK,
   input  logic        iRST_n,
   input  logic        iVS,
   input  logic        serve_n,
   input  logic [11:0] pL_ypos,
   input  logic [11:0] pR_ypos,
   output logic [31:0] ball,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r,
   output logic        point_pulse,
   output logic [2:0]  game_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DELAY = 3'd1,
      S_PLAY  = 3'd2,
      S_OVER  = 3'd3
   } state_t;

   localparam logic [10:0] X_CTR  = 11'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [10:0] Y_CTR  = 11'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
   localparam logic [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
   localparam logic [11:0] XR_HIT = 12'(PR_X - BALL_SIZE);
   localparam logic [11:0] XL_HIT = 12'(PL_X + PADDLE_W);
   localparam logic [11:0] VX     = 12'(VEL_X);
   localparam logic [11:0] VY     = 12'(VEL_Y);
   localparam logic [11:0] BS     = 12'(BALL_SIZE);
   localparam logic [11:0] PH     = 12'(PADDLE_H);
   localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
   localparam int          CNT_W  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

   state_t           state;
   logic             vs_q;
   logic [CNT_W-1:0] frame_cnt;
   logic [10:0]      x;
   logic [10:0]      y;
   logic             dir_x;
   logic             dir_y;

   logic             tick;
   logic [11:0]      x12;
   logic [11:0]      y12;
   logic [11:0]      ball_bot;
   logic [11:0]      pl_bot;
   logic [11:0]      pr_bot;
   logic             ovl_l;
   logic             ovl_r;
   logic             hit_l;
   logic             hit_r;
   logic             miss_l;
   logic             miss_r;
   logic [10:0]      x_step;
   logic [10:0]      y_step;
   logic             dx_step;
   logic             dy_step;
   logic [3:0]       sl_inc;
   logic [3:0]       sr_inc;

   assign tick = vs_q & ~iVS;

   assign x12 = {1'b0, x};
   assign y12 = {1'b0, y};

   // Vertical overlap uses wrapping 12-bit sums, so paddles near the top of the code space behave as the paddle logic sends them.
   assign ball_bot = y12 + BS;
   assign pl_bot   = pL_ypos + PH;
   assign pr_bot   = pR_ypos + PH;
   assign ovl_l    = (ball_bot > pL_ypos) && (y12 < pl_bot);
   assign ovl_r    = (ball_bot > pR_ypos) && (y12 < pr_bot);

   assign hit_r  =  dir_x && (x12 <= XR_HIT) && (x12 + VX >= XR_HIT) && ovl_r;
   assign miss_r =  dir_x && !hit_r && (x12 + VX >= X_MAX);
   assign hit_l  = !dir_x && (x12 >= XL_HIT) && (x12 <= XL_HIT + VX) && ovl_l;
   assign miss_l = !dir_x && !hit_l && (x12 < VX);

   assign sl_inc = (score_l >= WIN) ? score_l : score_l + 4'd1;
   assign sr_inc = (score_r >= WIN) ? score_r : score_r + 4'd1;

   // NOTE: every output of this block is given a default first, so no path leaves a latch behind.
   always_comb begin
      y_step  = y;
      dy_step = dir_y;
      x_step  = x;
      dx_step = dir_x;
      if (dir_y) begin
         if (y12 + VY >= Y_MAX) begin
            y_step  = 11'(Y_MAX);
            dy_step = 1'b0;
         end else begin
            y_step = 11'(y12 + VY);
         end
      end else begin
         if (y12 < VY) begin
            y_step  = '0;
            dy_step = 1'b1;
         end else begin
            y_step = 11'(y12 - VY);
         end
      end
      if (hit_r) begin
         x_step  = 11'(XR_HIT);
         dx_step = 1'b0;
      end else if (hit_l) begin
         x_step  = 11'(XL_HIT);
         dx_step = 1'b1;
      end else if (dir_x) begin
         x_step = 11'(x12 + VX);
      end else begin
         x_step = 11'(x12 - VX);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the async reset puts the
   // ball word at centre the moment iRST_n falls, with no clock edge required.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state       <= S_IDLE;
         vs_q        <= 1'b1;
         frame_cnt   <= '0;
         x           <= X_CTR;
         y           <= Y_CTR;
         dir_x       <= 1'b1;
         dir_y       <= 1'b1;
         score_l     <= '0;
         score_r     <= '0;
         point_pulse <= 1'b0;
      end else begin
         vs_q        <= iVS;
         point_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tick && !serve_n) begin
                  frame_cnt <= '0;
                  state     <= S_DELAY;
               end
            end
            S_DELAY: begin
               if (tick) begin
                  if (frame_cnt == CNT_LAST) begin
                     frame_cnt <= '0;
                     state     <= S_PLAY;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            S_PLAY: begin
               if (tick) begin
                  if (miss_r || miss_l) begin
                     // The ball restarts toward the player who just lost the point.
                     point_pulse <= 1'b1;
                     x           <= X_CTR;
                     y           <= Y_CTR;
                     dir_x       <= miss_r;
                     frame_cnt   <= '0;
                     if (miss_r) begin
                        score_l <= sl_inc;
                        state   <= (sl_inc == WIN) ? S_OVER : S_DELAY;
                     end else begin
                        score_r <= sr_inc;
                        state   <= (sr_inc == WIN) ? S_OVER : S_DELAY;
                     end
                  end else begin
                     x     <= x_step;
                     y     <= y_step;
                     dir_x <= dx_step;
                     dir_y <= dy_step;
                  end
               end
            end
            S_OVER: begin
               if (tick && !serve_n) begin
                  score_l   <= '0;
                  score_r   <= '0;
                  dir_x     <= 1'b1;
                  x         <= X_CTR;
                  y         <= Y_CTR;
                  frame_cnt <= '0;
                  state     <= S_DELAY;
               end
            end
            default: begin
               x     <= X_CTR;
               y     <= Y_CTR;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign ball       = {x, y, dir_x, dir_y, 8'h00};
   assign game_state = state;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: a per-frame reference model predicts every
// frame update, plus scenario tasks with hand-derived spot values.
module tb_pong_ball_engine;

   logic        iVGA_CLK = 1'b0;
   logic        iRST_n   = 1'b0;
   logic        iVS      = 1'b1;
   logic        serve_n  = 1'b1;
   logic [11:0] pL_ypos  = '0;
   logic [11:0] pR_ypos  = '0;
   logic [31:0] ball;
   logic [3:0]  score_l;
   logic [3:0]  score_r;
   logic        point_pulse;
   logic [2:0]  game_state;

   pong_ball_engine dut (
      .iVGA_CLK   (iVGA_CLK),
      .iRST_n     (iRST_n),
      .iVS        (iVS),
      .serve_n    (serve_n),
      .pL_ypos    (pL_ypos),
      .pR_ypos    (pR_ypos),
      .ball       (ball),
      .score_l    (score_l),
      .score_r    (score_r),
      .point_pulse(point_pulse),
      .game_state (game_state)
   );

   always #5 iVGA_CLK = ~iVGA_CLK;

   localparam logic [31:0] CENTRE_R = {11'd310, 11'd230, 1'b1, 1'b1, 8'h00};

   typedef struct {
      int x;
      int y;
      int dx;
      int dy;
      int sl;
      int sr;
      int st;
      int cnt;
      int pt;
   } mstate_t;

   typedef struct packed {
      logic [31:0] ball;
      logic [3:0]  sl;
      logic [3:0]  sr;
      logic        pulse;
      logic [2:0]  st;
   } exp_t;

   exp_t    sb_q[$];
   mstate_t m;
   int      n_cmp = 0;
   int      n_bad = 0;
   bit      pulse_chk = 1'b0;

   function automatic mstate_t reset_model();
      mstate_t r;
      r.x = 310; r.y = 230; r.dx = 1; r.dy = 1;
      r.sl = 0; r.sr = 0; r.st = 0; r.cnt = 0; r.pt = 0;
      return r;
   endfunction

   // Reference frame update written from the game rules with the default parameters.
   function automatic mstate_t model_step(mstate_t s, logic srv_n, int pl, int pr);
      mstate_t n;
      int ny, ndy, nx, ndx;
      bit ol, orr, pt_l, pt_r;
      n = s;
      n.pt = 0;
      case (s.st)
         0: if (!srv_n) begin n.st = 1; n.cnt = 0; end
         1: if (s.cnt == 59) begin n.st = 2; n.cnt = 0; end else n.cnt = s.cnt + 1;
         2: begin
            if (s.dy != 0) begin
               if (s.y + 2 >= 460) begin ny = 460; ndy = 0; end
               else begin ny = s.y + 2; ndy = 1; end
            end else begin
               if (s.y < 2) begin ny = 0; ndy = 1; end
               else begin ny = s.y - 2; ndy = 0; end
            end
            ol  = (((s.y + 20) % 4096) > pl) && (s.y < ((pl + 100) % 4096));
            orr = (((s.y + 20) % 4096) > pr) && (s.y < ((pr + 100) % 4096));
            pt_l = 0; pt_r = 0; nx = s.x; ndx = s.dx;
            if (s.dx != 0) begin
               if (s.x <= 480 && s.x + 3 >= 480 && orr) begin nx = 480; ndx = 0; end
               else if (s.x + 3 >= 620) pt_l = 1;
               else nx = s.x + 3;
            end else begin
               if (s.x >= 120 && s.x - 3 <= 120 && ol) begin nx = 120; ndx = 1; end
               else if (s.x < 3) pt_r = 1;
               else nx = s.x - 3;
            end
            if (pt_l || pt_r) begin
               n.pt = 1; n.x = 310; n.y = 230; n.cnt = 0;
               n.dx = pt_l ? 1 : 0;
               if (pt_l) n.sl = (s.sl < 9) ? s.sl + 1 : 9;
               else      n.sr = (s.sr < 9) ? s.sr + 1 : 9;
               n.st = (((pt_l != 0) ? n.sl : n.sr) == 9) ? 3 : 1;
            end else begin
               n.x = nx; n.y = ny; n.dx = ndx; n.dy = ndy;
            end
         end
         3: if (!srv_n) begin n.sl = 0; n.sr = 0; n.dx = 1; n.st = 1; n.cnt = 0; end
         default: n.st = 0;
      endcase
      return n;
   endfunction

   // One frame: iVS high for a cycle then falling; the expected result is queued as the edge is driven.
   task automatic do_tick();
      mstate_t n;
      exp_t e;
      @(negedge iVGA_CLK);
      iVS = 1'b1;
      @(negedge iVGA_CLK);
      iVS = 1'b0;
      n = model_step(m, serve_n, int'(pL_ypos), int'(pR_ypos));
      e.ball  = {11'(n.x), 11'(n.y), 1'(n.dx), 1'(n.dy), 8'h00};
      e.sl    = 4'(n.sl);
      e.sr    = 4'(n.sr);
      e.pulse = 1'(n.pt);
      e.st    = 3'(n.st);
      sb_q.push_back(e);
      m = n;
      @(posedge iVGA_CLK);
      #2;
   endtask

   always @(posedge iVGA_CLK) begin : sb_mon
      exp_t e;
      #1;
      if (pulse_chk) begin
         pulse_chk = 1'b0;
         n_cmp++;
         if (point_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_width: point_pulse=%b want 0", point_pulse);
         end
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         n_cmp++;
         if (ball !== e.ball) begin
            n_bad++;
            $display("FAIL sb_ball: got x=%0d y=%0d dx=%b dy=%b low=%h want x=%0d y=%0d dx=%b dy=%b",
                     ball[31:21], ball[20:10], ball[9], ball[8], ball[7:0],
                     e.ball[31:21], e.ball[20:10], e.ball[9], e.ball[8]);
         end
         n_cmp++;
         if (score_l !== e.sl) begin n_bad++; $display("FAIL sb_score_l: got %0d want %0d", score_l, e.sl); end
         n_cmp++;
         if (score_r !== e.sr) begin n_bad++; $display("FAIL sb_score_r: got %0d want %0d", score_r, e.sr); end
         n_cmp++;
         if (game_state !== e.st) begin n_bad++; $display("FAIL sb_state: got %0d want %0d", game_state, e.st); end
         n_cmp++;
         if (point_pulse !== e.pulse) begin n_bad++; $display("FAIL sb_pulse: got %b want %b", point_pulse, e.pulse); end
         if (e.pulse) pulse_chk = 1'b1;
      end
   end

   task automatic apply_reset();
      @(negedge iVGA_CLK);
      iRST_n = 1'b0;
      iVS    = 1'b1;
      repeat (2) @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      m = reset_model();
   endtask

   task automatic test_reset();
      iRST_n = 1'b0; iVS = 1'b1; serve_n = 1'b1; pL_ypos = '0; pR_ypos = '0;
      repeat (3) @(posedge iVGA_CLK);
      #2;
      n_cmp++;
      if (ball !== CENTRE_R) begin n_bad++; $display("FAIL reset_ball: got %h want %h", ball, CENTRE_R); end
      n_cmp++;
      if (score_l !== 4'd0 || score_r !== 4'd0) begin
         n_bad++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score_l, score_r);
      end
      n_cmp++;
      if (game_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", game_state); end
      n_cmp++;
      if (point_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", point_pulse); end
      @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      m = reset_model();
      do_tick();
      n_cmp++;
      if (game_state !== 3'd0) begin n_bad++; $display("FAIL idle_hold: got %0d want 0", game_state); end
   endtask

   task automatic test_serve();
      pR_ypos = 12'd300;
      pL_ypos = 12'd0;
      serve_n = 1'b0;
      do_tick();
      serve_n = 1'b1;
      n_cmp++;
      if (game_state !== 3'd1) begin n_bad++; $display("FAIL serve_to_delay: got %0d want 1", game_state); end
      repeat (59) do_tick();
      n_cmp++;
      if (game_state !== 3'd1) begin n_bad++; $display("FAIL delay_hold: got %0d want 1", game_state); end
      do_tick();
      n_cmp++;
      if (game_state !== 3'd2) begin n_bad++; $display("FAIL delay_done: got %0d want 2", game_state); end
      n_cmp++;
      if (ball !== CENTRE_R) begin n_bad++; $display("FAIL delay_centre: got %h want %h", ball, CENTRE_R); end
      do_tick();
      n_cmp++;
      if (ball !== {11'd313, 11'd232, 1'b1, 1'b1, 8'h00}) begin
         n_bad++; $display("FAIL first_move: got x=%0d y=%0d want x=313 y=232", ball[31:21], ball[20:10]);
      end
   endtask

   task automatic test_paddle_bounce();
      repeat (55) do_tick();
      do_tick();
      n_cmp++;
      if (ball !== {11'd480, 11'd344, 1'b0, 1'b1, 8'h00}) begin
         n_bad++; $display("FAIL paddle_hit: got x=%0d y=%0d dx=%b want x=480 y=344 dx=0",
                           ball[31:21], ball[20:10], ball[9]);
      end
      do_tick();
      n_cmp++;
      if (ball[31:21] !== 11'd477) begin n_bad++; $display("FAIL after_hit: got x=%0d want 477", ball[31:21]); end
   endtask

   task automatic test_right_miss();
      apply_reset();
      pR_ypos = 12'd100;
      serve_n = 1'b0;
      do_tick();
      serve_n = 1'b1;
      repeat (60) do_tick();
      repeat (103) do_tick();
      n_cmp++;
      if (game_state !== 3'd2 || point_pulse !== 1'b0) begin
         n_bad++; $display("FAIL pre_miss: got state=%0d pulse=%b want 2/0", game_state, point_pulse);
      end
      do_tick();
      n_cmp++;
      if (point_pulse !== 1'b1) begin n_bad++; $display("FAIL miss_pulse: got %b want 1", point_pulse); end
      n_cmp++;
      if (score_l !== 4'd1) begin n_bad++; $display("FAIL miss_score_l: got %0d want 1", score_l); end
      n_cmp++;
      if (ball !== CENTRE_R) begin n_bad++; $display("FAIL miss_recentre: got %h want %h", ball, CENTRE_R); end
      n_cmp++;
      if (game_state !== 3'd1) begin n_bad++; $display("FAIL miss_state: got %0d want 1", game_state); end
   endtask

   task automatic test_game_over();
      int guard;
      guard = 0;
      while (!(m.sl == 8 && m.st == 1) && guard < 2000) begin
         do_tick();
         guard++;
      end
      n_cmp++;
      if (score_l !== 4'd8) begin n_bad++; $display("FAIL reach_eight: got %0d want 8", score_l); end
      guard = 0;
      while (m.st != 3 && guard < 300) begin
         do_tick();
         guard++;
      end
      n_cmp++;
      if (score_l !== 4'd9 || game_state !== 3'd3) begin
         n_bad++; $display("FAIL game_over: got score_l=%0d state=%0d want 9/3", score_l, game_state);
      end
      n_cmp++;
      if (ball !== CENTRE_R) begin n_bad++; $display("FAIL over_centre: got %h want %h", ball, CENTRE_R); end
      repeat (3) do_tick();
      n_cmp++;
      if (game_state !== 3'd3 || score_l !== 4'd9) begin
         n_bad++; $display("FAIL over_hold: got state=%0d score_l=%0d want 3/9", game_state, score_l);
      end
      serve_n = 1'b0;
      do_tick();
      serve_n = 1'b1;
      n_cmp++;
      if (score_l !== 4'd0 || score_r !== 4'd0 || game_state !== 3'd1 || ball[9] !== 1'b1) begin
         n_bad++; $display("FAIL restart: got scores=%0d/%0d state=%0d dx=%b want 0/0 1 1",
                           score_l, score_r, game_state, ball[9]);
      end
   endtask

   task automatic test_wall_bounce();
      mstate_t pre;
      int top_seen, bot_seen;
      top_seen = 0;
      bot_seen = 0;
      repeat (60) do_tick();
      for (int i = 0; i < 600; i++) begin
         pL_ypos = 12'(m.y);
         pR_ypos = 12'(m.y);
         pre = m;
         do_tick();
         if (pre.st == 2 && pre.dy == 0 && pre.y < 2) begin
            top_seen++;
            n_cmp++;
            if (ball[20:10] !== 11'd0 || ball[8] !== 1'b1) begin
               n_bad++; $display("FAIL top_wall: got y=%0d dy=%b want 0/1", ball[20:10], ball[8]);
            end
         end
         if (pre.st == 2 && pre.dy == 1 && pre.y == 458) begin
            bot_seen++;
            n_cmp++;
            if (ball[20:10] !== 11'd460 || ball[8] !== 1'b0) begin
               n_bad++; $display("FAIL bottom_wall: got y=%0d dy=%b want 460/0", ball[20:10], ball[8]);
            end
         end
      end
      n_cmp++;
      if (top_seen == 0 || bot_seen == 0) begin
         n_bad++; $display("FAIL wall_reached: top=%0d bottom=%0d want both nonzero", top_seen, bot_seen);
      end
      n_cmp++;
      if (score_l !== 4'd0 || score_r !== 4'd0 || game_state !== 3'd2) begin
         n_bad++; $display("FAIL rally_no_point: got scores=%0d/%0d state=%0d want 0/0 2",
                           score_l, score_r, game_state);
      end
   endtask

   task automatic test_reset_midplay();
      @(posedge iVGA_CLK);
      #3;
      iRST_n = 1'b0;
      #1;
      n_cmp++;
      if (ball !== CENTRE_R) begin n_bad++; $display("FAIL async_ball: got %h want %h", ball, CENTRE_R); end
      n_cmp++;
      if (game_state !== 3'd0) begin n_bad++; $display("FAIL async_state: got %0d want 0", game_state); end
      iVS = 1'b1;
      repeat (2) @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      m = reset_model();
   endtask

   task automatic test_left_miss();
      int guard;
      pL_ypos = 12'd1500;
      serve_n = 1'b0;
      do_tick();
      serve_n = 1'b1;
      repeat (60) do_tick();
      guard = 0;
      do begin
         pR_ypos = 12'(m.y);
         do_tick();
         guard++;
      end while (m.st == 2 && guard < 400);
      n_cmp++;
      if (point_pulse !== 1'b1) begin n_bad++; $display("FAIL left_pulse: got %b want 1", point_pulse); end
      n_cmp++;
      if (score_r !== 4'd1 || score_l !== 4'd0) begin
         n_bad++; $display("FAIL left_score: got %0d/%0d want 0/1", score_l, score_r);
      end
      n_cmp++;
      if (ball[9] !== 1'b0 || game_state !== 3'd1) begin
         n_bad++; $display("FAIL left_serve_dir: got dx=%b state=%0d want 0/1", ball[9], game_state);
      end
   endtask

   initial begin
      m = reset_model();
      test_reset();
      test_serve();
      test_paddle_bounce();
      test_right_miss();
      test_game_over();
      test_wall_bounce();
      test_reset_midplay();
      test_left_miss();
      repeat (3) @(posedge iVGA_CLK);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
